alu_seq: RTL



---
 rtl/alu_seq.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered eight-op ALU with iterative shift-add multiply; ALU_ACC_EN adds the accumulator operand
module alu_seq #(
    parameter int N       = 8,
    parameter int MUL_LAT = N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   opcode,
    input  logic         mode,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         use_acc,
    output logic [N-1:0] result,
    output logic [3:0]   status,
    output logic [3:0]   flags,
    output logic         err,
    output logic         out_valid
);
    localparam int SW = $clog2(N);
    localparam int CW = $clog2(MUL_LAT + 1);

    typedef enum logic {IDLE, BUSY} state_t;
    state_t state, state_nxt;

    logic           accept, onehot, is_mul, last_step, step_en, done;
    logic [N-1:0]   opa, alu_res, res_d;
    logic           alu_c, alu_v, err_d;
    logic [3:0]     st_d, flg_d;
    logic [SW-1:0]  sh;
    logic           sh_big;
    logic [N:0]     sum, dif, shl, shr;
    logic [2*N-1:0] prod, prod_nxt, mcand;
    logic [N-1:0]   mplier;
    logic [CW-1:0]  cnt;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;
    assign onehot   = (opcode != 4'b0) && ((opcode & (opcode - 4'd1)) == 4'b0);
    assign is_mul   = mode && (opcode == 4'b1000);

`ifdef ALU_ACC_EN
    logic [N-1:0] acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (done) begin
            acc <= res_d;
        end
    end

    assign opa = use_acc ? acc : a;
`else
    logic unused_use_acc;
    assign unused_use_acc = use_acc;
    assign opa = a;
`endif

    assign sh     = b[SW-1:0];
    assign sh_big = 32'(sh) >= N;

    // Extra bit on each side catches carry/borrow and the last bit shifted out.
    assign sum = {1'b0, opa} + {1'b0, b};
    assign dif = {1'b0, opa} - {1'b0, b};
    assign shl = {1'b0, opa} << sh;
    assign shr = {opa, 1'b0} >> sh;

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case ({mode, opcode})
            5'b0_1000: begin
                {alu_c, alu_res} = sum;
                alu_v = (opa[N-1] == b[N-1]) && (sum[N-1] != opa[N-1]);
            end
            5'b0_0100: begin
                {alu_c, alu_res} = dif;
                alu_v = (opa[N-1] != b[N-1]) && (dif[N-1] != opa[N-1]);
            end
            5'b0_0010: alu_res = opa | b;
            5'b0_0001: alu_res = opa & b;
            5'b1_0100: alu_res = opa ^ b;
            5'b1_0010: if (!sh_big) {alu_res, alu_c} = shr;
            5'b1_0001: if (!sh_big) {alu_c, alu_res} = shl;
            default: ;
        endcase
    end

    // Partial products stop after N steps even if MUL_LAT keeps the FSM busy longer.
    assign step_en   = 32'(cnt) < N;
    assign last_step = (cnt == CW'(MUL_LAT - 1));
    assign prod_nxt  = (step_en && mplier[0]) ? prod + mcand : prod;

    always_comb begin
        done  = 1'b0;
        res_d = '0;
        st_d  = 4'b0;
        flg_d = 4'b0;
        err_d = 1'b0;
        if (state == BUSY) begin
            if (last_step) begin
                done  = 1'b1;
                res_d = prod_nxt[N-1:0];
                st_d  = 4'b1000;
                flg_d = {res_d[N-1], res_d == '0, |prod_nxt[2*N-1:N], 1'b0};
            end
        end else if (accept) begin
            if (!onehot) begin
                done  = 1'b1;
                flg_d = 4'b0100;
                err_d = 1'b1;
            end else if (!is_mul) begin
                done  = 1'b1;
                res_d = alu_res;
                st_d  = opcode;
                flg_d = {alu_res[N-1], alu_res == '0, alu_c, alu_v};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept && onehot && is_mul) state_nxt = BUSY;
            BUSY: if (last_step) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result    <= '0;
            status    <= 4'b0;
            flags     <= 4'b0;
            err       <= 1'b0;
            out_valid <= 1'b0;
            prod      <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
        end else begin
            out_valid <= done;
            if (done) begin
                result <= res_d;
                status <= st_d;
                flags  <= flg_d;
                err    <= err_d;
            end
            if (accept && onehot && is_mul) begin
                prod   <= '0;
                mcand  <= {{N{1'b0}}, opa};
                mplier <= b;
                cnt    <= '0;
            end else if (state == BUSY) begin
                prod   <= prod_nxt;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + CW'(1);
            end
        end
    end
endmodule
